// File: rtl/text_line_flusher.sv
// text_line_flusher: walks each glyph cell pixel by pixel and emits registered VGA plot commands.
module text_line_flusher #(
  parameter int CELL_W      = 8,
  parameter int CELL_H      = 10,
  parameter int CHAR_PITCH  = 10,
  parameter int MAX_CHARS   = 16,
  parameter bit TRANSPARENT = 1'b0
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start_i,
  input  logic       hold_i,
  input  logic [7:0] origin_x_i,
  input  logic [7:0] origin_y_i,
  input  logic [4:0] char_count_i,
  input  logic [5:0] bg_colour_i,
  output logic [4:0] char_index_o,
  output logic [7:0] char_x_o,
  output logic [7:0] char_y_o,
  output logic [7:0] flush_x_o,
  output logic [7:0] flush_y_o,
  input  logic [5:0] glyph_colour_i,
  input  logic       glyph_enable_i,
  output logic [7:0] vga_x_o,
  output logic [7:0] vga_y_o,
  output logic [5:0] vga_colour_o,
  output logic       plot_o,
  output logic       busy_o,
  output logic       done_o
);
  localparam int CW = CELL_W > 1 ? $clog2(CELL_W) : 1;
  localparam int RW = CELL_H > 1 ? $clog2(CELL_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(CELL_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(CELL_H - 1);
  localparam logic [4:0] CNT_MAX = 5'(MAX_CHARS);
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [4:0] idx_q, idx_d, cnt_q, cnt_d, cnt_in;
  logic [7:0] cx_q, cx_d, oy_q, oy_d, vx_q, vx_d, vy_q, vy_d;
  logic [5:0] bg_q, bg_d, vc_q, vc_d;
  logic plot_q, plot_d, col_end, row_end, last;
  assign char_index_o = idx_q;
  assign char_x_o     = cx_q;
  assign char_y_o     = oy_q;
  assign flush_x_o    = cx_q + 8'(col_q);
  assign flush_y_o    = oy_q + 8'(row_q);
  assign vga_x_o      = vx_q;
  assign vga_y_o      = vy_q;
  assign vga_colour_o = vc_q;
  assign plot_o       = plot_q;
  assign busy_o       = state_q == SCAN || state_q == DRAIN;
  assign done_o       = state_q == DONE;
  assign cnt_in  = char_count_i > CNT_MAX ? CNT_MAX : char_count_i;
  assign col_end = col_q == COL_LAST;
  assign row_end = row_q == ROW_LAST;
  assign last    = col_end && row_end && idx_q == cnt_q - 5'd1;
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    cx_d    = cx_q;
    oy_d    = oy_q;
    bg_d    = bg_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    vc_d    = vc_q;
    plot_d  = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = cnt_in == 5'd0 ? DONE : SCAN;
        cnt_d   = cnt_in;
        cx_d    = origin_x_i;
        oy_d    = origin_y_i;
        bg_d    = bg_colour_i;
        col_d   = '0;
        row_d   = '0;
        idx_d   = '0;
      end
      SCAN: begin
        plot_d  = glyph_enable_i | ~TRANSPARENT;
        vx_d    = flush_x_o;
        vy_d    = flush_y_o;
        vc_d    = glyph_enable_i ? glyph_colour_i : bg_q;
        col_d   = col_end ? '0 : col_q + 1'b1;
        row_d   = col_end ? (row_end ? '0 : row_q + 1'b1) : row_q;
        idx_d   = col_end && row_end ? idx_q + 5'd1 : idx_q;
        cx_d    = col_end && row_end ? cx_q + 8'(CHAR_PITCH) : cx_q;
        state_d = last ? DRAIN : SCAN;
      end
      DRAIN:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      cx_q    <= '0;
      oy_q    <= '0;
      bg_q    <= '0;
      vx_q    <= '0;
      vy_q    <= '0;
      vc_q    <= '0;
      plot_q  <= 1'b0;
    end else if (!hold_i) begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      cx_q    <= cx_d;
      oy_q    <= oy_d;
      bg_q    <= bg_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      vc_q    <= vc_d;
      plot_q  <= plot_d;
    end
  end
endmodule

// File: tb/tb_text_line_flusher.sv
// tb_text_line_flusher: opaque and transparent instances driven in parallel against a pixel-order model.
module tb_text_line_flusher;
  logic clk = 1'b0, resetn = 1'b0, start_i = 1'b0, hold_i = 1'b0;
  logic [7:0] origin_x_i = '0, origin_y_i = '0;
  logic [4:0] char_count_i = '0;
  logic [5:0] bg_colour_i = '0;
  logic [1:0][4:0] cidx;
  logic [1:0][7:0] cx, cy, fx, fy, vx, vy;
  logic [1:0][5:0] vc;
  logic [1:0] gen, plot, busy, done;
  int n_vec = 0, n_bad = 0;
  int pc[2];
  always #5 clk = ~clk;
  for (genvar k = 0; k < 2; k++) begin : g_dut
    assign gen[k] = (fx[k] - cx[k]) == 8'd3;
    text_line_flusher #(.TRANSPARENT(k == 1)) dut (
      .clk(clk), .resetn(resetn), .start_i(start_i), .hold_i(hold_i),
      .origin_x_i(origin_x_i), .origin_y_i(origin_y_i), .char_count_i(char_count_i),
      .bg_colour_i(bg_colour_i), .char_index_o(cidx[k]), .char_x_o(cx[k]), .char_y_o(cy[k]),
      .flush_x_o(fx[k]), .flush_y_o(fy[k]), .glyph_colour_i(6'h3F), .glyph_enable_i(gen[k]),
      .vga_x_o(vx[k]), .vga_y_o(vy[k]), .vga_colour_o(vc[k]), .plot_o(plot[k]),
      .busy_o(busy[k]), .done_o(done[k]));
  end
  typedef struct {
    logic [4:0] cnt;
    logic [7:0] ox, oy;
    logic [5:0] bg;
    int px, tplots, hold_at, start_at;
  } vec_t;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask
  task automatic chk_reset();
    for (int k = 0; k < 2; k++) begin
      chk("rst_plot", plot[k], 0);
      chk("rst_busy", busy[k], 0);
      chk("rst_done", done[k], 0);
      chk("rst_vga", {vx[k], vy[k], vc[k]}, 0);
      chk("rst_coords", {cx[k], cy[k], fx[k], fy[k], cidx[k]}, 0);
    end
  endtask
  task automatic check_at(input int j, input vec_t v);
    int q;
    logic en;
    for (int k = 0; k < 2; k++) begin
      chk("busy", busy[k], v.px > 0 && j <= v.px);
      chk("done", done[k], j == (v.px == 0 ? 0 : v.px + 1));
      if (j < v.px) begin
        chk("flush_x", fx[k], 8'(v.ox + (j / 80) * 10 + j % 8));
        chk("flush_y", fy[k], 8'(v.oy + (j % 80) / 8));
        chk("char_x", cx[k], 8'(v.ox + (j / 80) * 10));
        chk("char_y", cy[k], v.oy);
        chk("char_index", cidx[k], j / 80);
      end
      if (j >= 1 && j <= v.px) begin
        q = j - 1;
        en = q % 8 == 3;
        chk("plot", plot[k], k == 0 ? 1'b1 : en);
        if (k == 0 || en) begin
          chk("vga_x", vx[k], 8'(v.ox + (q / 80) * 10 + q % 8));
          chk("vga_y", vy[k], 8'(v.oy + (q % 80) / 8));
          chk("vga_colour", vc[k], k == 0 && !en ? v.bg : 6'h3F);
        end
      end else chk("plot_idle", plot[k], 0);
    end
  endtask
  task automatic run(input vec_t v);
    int j = 0, e = 0;
    logic h;
    pc[0] = 0;
    pc[1] = 0;
    char_count_i = v.cnt;
    origin_x_i = v.ox;
    origin_y_i = v.oy;
    bg_colour_i = v.bg;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    origin_x_i = ~v.ox;
    origin_y_i = ~v.oy;
    bg_colour_i = ~v.bg;
    char_count_i = 5'd1;
    check_at(0, v);
    while (j <= v.px + 2 && e < v.px + 20) begin
      e++;
      h = v.hold_at > 0 && e >= v.hold_at && e < v.hold_at + 5;
      hold_i = h;
      start_i = e == v.start_at;
      @(posedge clk);
      #1;
      hold_i = 1'b0;
      start_i = 1'b0;
      if (!h) j++;
      if (j <= v.px + 2) check_at(j, v);
      for (int k = 0; k < 2; k++) if (!h && plot[k]) pc[k]++;
    end
    chk("timeout", j > v.px + 2, 1);
    chk("plots_opaque", pc[0], v.px);
    chk("plots_transparent", pc[1], v.tplots);
    @(posedge clk);
    #1;
  endtask
  vec_t vecs[7];
  initial begin
    vecs[0] = '{5'd1, 8'd20, 8'd30, 6'h2A, 80, 10, -1, -1};
    vecs[1] = '{5'd3, 8'd0, 8'd0, 6'h15, 240, 30, -1, -1};
    vecs[2] = '{5'd1, 8'd250, 8'd5, 6'h01, 80, 10, -1, -1};
    vecs[3] = '{5'd0, 8'd7, 8'd7, 6'h03, 0, 0, -1, -1};
    vecs[4] = '{5'd2, 8'd40, 8'd250, 6'h2B, 160, 20, 30, 50};
    vecs[5] = '{5'd20, 8'd100, 8'd60, 6'h11, 1280, 160, -1, -1};
    vecs[6] = '{5'd1, 8'd5, 8'd5, 6'h00, 80, 10, -1, 10};
    repeat (2) @(posedge clk);
    #1;
    chk_reset();
    resetn = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) run(vecs[i]);
    char_count_i = 5'd2;
    origin_x_i = 8'd60;
    origin_y_i = 8'd70;
    bg_colour_i = 6'h0C;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    chk_reset();
    resetn = 1'b1;
    @(posedge clk);
    #1;
    chk_reset();
    run(vecs[0]);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/text_line_flusher.md
Name: text_line_flusher

Overview:
- Sequential pixel scanner for drawing a line of glyph characters.
- Per character it walks every pixel of a fixed glyph cell and drives the current pixel coordinate (flush_x/flush_y) plus the cell origin to the combinational glyph decoders.
- It samples their colour/enable pair and emits registered plot commands to the VGA adapter, with a start/busy/done handshake toward the game controller.
- Sits between the character glyph LUT decoders and the VGA adapter.

Parameters:
- CELL_W, 8, glyph cell width in pixels (columns 0..CELL_W-1).
- CELL_H, 10, glyph cell height in pixels (rows 0..CELL_H-1).
- CHAR_PITCH, 10, horizontal distance in pixels between consecutive character origins.
- MAX_CHARS, 16, maximum characters per line; char_count width is 5 bits.
- TRANSPARENT, 0, 1: pixels with glyph_enable=0 are skipped (plot low). 0: they are written with bg_colour.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset, sampled on rising clk
- start  in  1  begin a line; accepted only in IDLE
- hold  in  1  freeze; when high, all state, counters and outputs keep their values
- origin_x  in  8  x of first character origin
- origin_y  in  8  y of line origin
- char_count  in  5  number of characters, 0..MAX_CHARS; values >MAX_CHARS clamp to MAX_CHARS
- bg_colour  in  6  colour for disabled pixels when TRANSPARENT=0
- char_index  out  5  index of the character currently being scanned (selects the decoder upstream)
- char_x  out  8  current cell origin x = origin_x + char_index*CHAR_PITCH (mod 256)
- char_y  out  8  current cell origin y = origin_y
- flush_x  out  8  current pixel x = char_x + col (mod 256)
- flush_y  out  8  current pixel y = char_y + row (mod 256)
- glyph_colour  in  6  decoder colour for (flush_x, flush_y), combinational
- glyph_enable  in  1  decoder hit for (flush_x, flush_y)
- vga_x  out  8  registered plot x
- vga_y  out  8  registered plot y
- vga_colour  out  6  registered plot colour
- plot  out  1  one-cycle write strobe per emitted pixel
- busy  out  1  high while a line is in progress
- done  out  1  one-cycle pulse when the line is complete

Behaviour:
- Reset (resetn=0 at clk edge, takes priority over everything, including mid-line):
  - state=IDLE; counters col, row and char_index = 0.
  - plot=0, busy=0, done=0.
  - vga_x/vga_y/vga_colour = 0; char_x/char_y/flush_x/flush_y = 0.
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE:
  - start=1 with char_count>0: latch origin_x, origin_y, char_count and bg_colour; zero the counters; go to SCAN.
  - start=1 with char_count=0: go to DONE directly, with no plots.
- SCAN, one pixel presented per cycle:
  - The glyph pair is sampled the same cycle (decoder is combinational) and registered into vga_* and plot the next cycle. Latency from presentation to plot is 1 cycle.
  - Order: char_index outermost, row middle, col innermost (col increments fastest).
  - col wraps CELL_W-1 -> 0 and increments row. row wraps CELL_H-1 -> 0 and increments char_index.
  - After presenting the last pixel (char_count-1, CELL_H-1, CELL_W-1), go to DRAIN.
- DRAIN: emits the final registered pixel; next state DONE.
- DONE: done=1 for exactly one cycle; return to IDLE.
- plot value per registered pixel:
  - glyph_enable=1: plot=1, vga_colour=glyph_colour.
  - glyph_enable=0 and TRANSPARENT=0: plot=1, vga_colour=bg_colour.
  - glyph_enable=0 and TRANSPARENT=1: plot=0.
- busy is high in SCAN and DRAIN; low in IDLE and DONE.
- Timing for P = char_count*CELL_W*CELL_H, with start accepted at edge T:
  - pixels presented cycles T+1..T+P;
  - plots at T+2..T+P+1;
  - done at T+P+2.
- start while busy or in DONE is ignored; inputs are not re-latched.
- Arithmetic: all coordinates are 8-bit modulo 256; wrap-around is allowed, with no clipping.
- hold=1 freezes the pipeline, including the registered plot. A plot already high stays high (the adapter sees a repeated write of the same pixel, which is harmless). done stays high while held in DONE.
- Origin inputs changing mid-line have no effect (latched values are used).

Test Plan:
- Reset mid-line: resetn=0 during SCAN -> next cycle plot=0, busy=0, done=0, all outputs 0, state IDLE. A following start restarts from pixel (0,0).
- Single char, TRANSPARENT=0, origin (20,30), decoder stub hits column 3 rows 0..9 with colour 3F:
  - exactly 80 plots at T+2..T+81;
  - (23,30..39) carry 3F; the other 70 carry bg_colour;
  - done pulse at T+82.
- Three chars, TRANSPARENT=1, origin (0,0):
  - char_x steps 0, 10, 20;
  - plots occur only on enabled pixels;
  - last pixel presented is (27,9);
  - done at T+242.
- char_count=0 -> no plot, busy stays 0, done pulse at T+1. start asserted during SCAN -> ignored, total plot count unchanged.
- Wrap: origin_x=250, one char -> flush_x sequence 250..255, 0, 1 per row.
- hold: hold=1 for 5 cycles mid-scan -> outputs frozen, total plots unchanged, done delayed by exactly 5 cycles.
